// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: 3-bit opcode encoding, FSM states and a shift-op helper.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_PASS = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_XOR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/seq_alu_comb.sv
// Single-cycle datapath of seq_alu: add/sub with carry-in, logic ops and pass-through.
// Shift opcodes fall through as PASS; the top sequences shifts itself.
module seq_alu_comb
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_op,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // MSB of the (WIDTH+1)-bit difference is the borrow out.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_cin};

  always_comb begin
    o_res   = i_a;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_res   = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_res   = w_diff[WIDTH-1:0];
        o_carry = w_diff[WIDTH];
        o_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      default: o_res = i_a;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes; shifts run one bit per cycle.
// Define SEQ_ALU_CARRY_CHAIN_EN to feed the previous carry_f into ADD/SUB.
//   state  | meaning
//   S_IDLE | waiting for an operation, in_ready=1
//   S_EXEC | shifting working register, counter counts down to 1
//   S_DONE | result/flags valid, held until out_ready
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             carry_f,
  output logic             negative_f,
  output logic             overflow_f,
  output logic             busy
);

  localparam int KW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  op_e              r_op;
  logic [WIDTH-1:0] r_work;
  logic [KW-1:0]    r_cnt;

  op_e              w_op_in;
  logic [KW-1:0]    w_k;
  logic             w_cin;
  logic             w_load_done;
  logic             w_load_exec;
  logic             w_shift_done;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic [WIDTH-1:0] w_work_nxt;
  logic             w_shout;

  assign w_op_in = op_e'(op_sel);
  assign w_k     = b[KW-1:0];

`ifdef SEQ_ALU_CARRY_CHAIN_EN
  assign w_cin = carry_f;
`else
  assign w_cin = 1'b0;
`endif

  seq_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a    (a),
    .i_b    (b),
    .i_op   (w_op_in),
    .i_cin  (w_cin),
    .o_res  (w_res),
    .o_carry(w_carry),
    .o_ovf  (w_ovf)
  );

  assign w_work_nxt = (r_op == OP_SHL) ? {r_work[WIDTH-2:0], 1'b0} : {1'b0, r_work[WIDTH-1:1]};
  assign w_shout    = (r_op == OP_SHL) ? r_work[WIDTH-1] : r_work[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    w_load_done  = 1'b0;
    w_load_exec  = 1'b0;
    w_shift_done = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_EXEC: begin
        if (r_cnt == KW'(1)) begin
          w_state_nxt  = S_DONE;
          w_shift_done = 1'b1;
        end
      end
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready && !in_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new operation can be taken in IDLE or in the same edge DONE is released.
    if (in_valid && in_ready) begin
      if (is_shift(w_op_in) && (w_k != '0)) begin
        w_state_nxt = S_EXEC;
        w_load_exec = 1'b1;
      end else begin
        w_state_nxt = S_DONE;
        w_load_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_ADD;
      r_work     <= '0;
      r_cnt      <= '0;
      result     <= '0;
      zero_f     <= 1'b0;
      carry_f    <= 1'b0;
      negative_f <= 1'b0;
      overflow_f <= 1'b0;
    end else begin
      if (w_load_exec) begin
        r_op   <= w_op_in;
        r_work <= a;
        r_cnt  <= w_k;
      end else if (r_state == S_EXEC) begin
        r_work <= w_work_nxt;
        r_cnt  <= r_cnt - KW'(1);
      end
      if (w_load_done) begin
        result     <= w_res;
        carry_f    <= w_carry;
        overflow_f <= w_ovf;
        zero_f     <= (w_res == '0);
        negative_f <= w_res[WIDTH-1];
      end else if (w_shift_done) begin
        result     <= w_work_nxt;
        carry_f    <= w_shout;
        overflow_f <= 1'b0;
        zero_f     <= (w_work_nxt == '0);
        negative_f <= w_work_nxt[WIDTH-1];
      end
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, datapath width; legal values 4, 8, 16, 32.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept; transfer when in_valid & in_ready at clk edge.
REQ-006 a, b  input  WIDTH each  operands; for shifts, b[$clog2(WIDTH)-1:0] = shift amount k.
REQ-007 op_sel  input  3  opcode: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 PASS a, 5 SHL, 6 SHR logical, 7 XOR.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts; transfer when out_valid & out_ready.
REQ-010 result  output  WIDTH  registered result.
REQ-011 zero_f, carry_f, negative_f, overflow_f  output  1 each  registered flags.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DONE.
REQ-014 IDLE: in_ready=1; on transfer, latch a, b, op_sel; non-shift op or k=0 -> DONE; shift with k>0 -> EXEC, counter=k.
REQ-015 EXEC: shift working register by one bit per cycle, decrement counter; at counter=1 -> DONE; in_ready=0.
REQ-016 Latency: out_valid rises 1 cycle after input transfer for non-shift ops and k=0; 1+k cycles for shifts with k>0.
REQ-017 DONE: out_valid=1; result/flags stable until out_ready; out_ready=0 holds DONE.
REQ-018 in_ready SHALL also be 1 in DONE when out_ready=1; simultaneous output and input transfer accepts the new operation in the same edge (back-to-back, no IDLE cycle); DONE & out_ready & ~in_valid -> IDLE.
REQ-019 ADD: {carry, result} = a + b + cin, WIDTH+1-bit sum; SUB: result = a - b - cin mod 2^WIDTH, carry_f = borrow out (1 when a < b + cin unsigned).
REQ-020 overflow_f: ADD -> operands same sign, result sign differs; SUB -> operand signs differ, result sign differs from a; 0 for all other ops.
REQ-021 carry_f for SHL/SHR with k>0 = last bit shifted out; 0 for k=0 and for AND, OR, PASS, XOR.
REQ-022 zero_f = (result == 0); negative_f = result[WIDTH-1]; computed on final result only.
REQ-023 Shift amounts wrap modulo WIDTH: upper bits of b ignored.
REQ-024 Outputs result/flags SHALL change only on entry to DONE; no intermediate EXEC values visible.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter=0, out_valid=0, result=0, all flags 0, busy=0, in_ready=1 after release.
REQ-026 Reset during EXEC or DONE SHALL discard the in-flight operation; no out_valid follows.

Configuration
REQ-027 Macro SEQ_ALU_CARRY_CHAIN_EN: defined -> cin for ADD/SUB = carry_f of the last completed operation (multi-word chaining); undefined -> cin = 0 always.
REQ-028 carry_f after reset SHALL be 0, so the first chained ADD/SUB uses cin=0 in both builds.

Structure
REQ-029 Package seq_alu_pkg SHALL hold the opcode enum (3-bit) and FSM state enum.
REQ-030 Combinational ops (ADD, SUB, AND, OR, PASS, XOR, overflow/carry) SHALL reside in sub-module seq_alu_comb, parameterised by WIDTH; shift sequencing stays in seq_alu.

Verification (WIDTH=8 unless noted)
REQ-031 ADD a=0x7F, b=0x01 -> 1 cycle later result=0x80, overflow_f=1, negative_f=1, carry_f=0, zero_f=0.
REQ-032 SUB a=0x00, b=0x01 -> result=0xFF, carry_f=1, overflow_f=0; then SUB 0x05-0x05 with macro defined -> result=0xFF (cin=1), undefined -> 0x00 with zero_f=1.
REQ-033 SHL a=0x81, b=0x03 -> out_valid 4 cycles after transfer, result=0x08, carry_f=0; SHR a=0x81, b=0x01 -> result=0x40, carry_f=1, latency 2.
REQ-034 out_ready held 0 for 5 cycles in DONE -> result/flags stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same edge, next result 1 cycle later.
REQ-035 rst_n pulsed low during EXEC of SHL k=7 -> out_valid=0, all outputs 0, busy=0 immediately; next op completes normally.
REQ-036 WIDTH=16: ADD 0xFFFF+0x0001 -> result=0x0000, carry_f=1, zero_f=1; SHL b=0x0013 -> k=3.
